alu_sequencer: RTL and testbench

Multi-cycle R-type execution sequencer that drives the 32-bit combinational ALU from the controlling side. It accepts one 32-bit R-type instruction per handshake, reads both source registers from the register file, and presents `OP1`/`OP2`/`OPRN` to the ALU. It then writes `OUT` back to `rd` and reports the ALU `ZERO` flag. It sits between the instruction fetch/decode path and the datapath (ALU + register file) of the processor.

---
 rtl/alu_sequencer_pkg.sv | 52 +++++
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/alu_sequencer_funct_decode.sv | 30 +++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the R-type ALU sequencer: funct codes,
// ALU operation codes, FSM state encoding and the decode result record.
package alu_sequencer_pkg;

    localparam int DATA_INDEX_LIMIT = 31;
    localparam int DATA_W           = DATA_INDEX_LIMIT + 1;
    localparam int REG_AW           = 5;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2c;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_SRL  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;

    // Entry i of the table maps to ALU opcode i+1.
    localparam int N_FN = 9;
    localparam logic [N_FN-1:0][5:0] FN_TABLE =
        {FN_SLT, FN_NOR, FN_OR, FN_AND, FN_SLL, FN_SRL, FN_MUL, FN_SUB, FN_ADD};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] oprn;
        logic       is_shift;
        logic       illegal;
    } decode_t;

    function automatic logic fn_is_shift(input logic [5:0] funct);
        return (funct == FN_SRL) || (funct == FN_SLL);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of instruction handshake, register-file and ALU signals seen by the
// sequencer (master) and by the datapath/fetch side (slave).
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    logic              rf_read;
    logic [REG_AW-1:0] rf_addr_r1;
    logic [REG_AW-1:0] rf_addr_r2;
    logic [DATA_W-1:0] rf_data_r1;
    logic [DATA_W-1:0] rf_data_r2;
    logic              rf_write;
    logic [REG_AW-1:0] rf_addr_w;
    logic [DATA_W-1:0] rf_data_w;

    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [3:0]        alu_oprn;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    logic              done;
    logic              zero_flag;
    logic              illegal;

    modport master (
        input  instr, instr_valid, rf_data_r1, rf_data_r2, alu_out, alu_zero,
        output instr_ready, rf_read, rf_addr_r1, rf_addr_r2, rf_write,
               rf_addr_w, rf_data_w, alu_op1, alu_op2, alu_oprn,
               done, zero_flag, illegal
    );

    modport slave (
        output instr, instr_valid, rf_data_r1, rf_data_r2, alu_out, alu_zero,
        input  instr_ready, rf_read, rf_addr_r1, rf_addr_r2, rf_write,
               rf_addr_w, rf_data_w, alu_op1, alu_op2, alu_oprn,
               done, zero_flag, illegal
    );

endinterface

// File: rtl/alu_sequencer_funct_decode.sv
// Combinational funct decoder: ALU opcode, shift-operand selection and
// illegal-instruction flag.
module alu_sequencer_funct_decode
    import alu_sequencer_pkg::*;
(
    input  logic [5:0] funct,
    output decode_t    dec
);

    logic [N_FN-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_FN; gi++) begin : g_match
            assign hit[gi] = (funct == FN_TABLE[gi]);
        end
    endgenerate

    always_comb begin
        dec = '0;
        for (int i = 0; i < N_FN; i++) begin
            if (hit[i]) begin
                dec.oprn = 4'(i + 1);
            end
        end
        dec.is_shift = fn_is_shift(funct);
        dec.illegal  = ~|hit;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-cycle R-type sequencer: accept, read operands, drive the ALU, write
// the result back and report completion, zero and illegal status.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);

    state_t            state_reg;
    state_t            state_next;
    logic [25:0]       instr_reg;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] op2_reg;
    logic [3:0]        oprn_reg;
    logic              zero_reg;
    decode_t           dec;

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;

    assign rs    = instr_reg[25:21];
    assign rt    = instr_reg[20:16];
    assign rd    = instr_reg[15:11];
    assign shamt = instr_reg[10:6];

    alu_sequencer_funct_decode u_decode (
        .funct (instr_reg[5:0]),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.instr_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.rf_read     = 1'b0;
        bus.rf_addr_r1  = '0;
        bus.rf_addr_r2  = '0;
        bus.rf_write    = 1'b0;
        bus.rf_addr_w   = '0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        case (state_reg)
            ST_IDLE: bus.instr_ready = 1'b1;
            ST_READ: begin
                bus.rf_read    = 1'b1;
                bus.rf_addr_r1 = rs;
                bus.rf_addr_r2 = rt;
            end
            ST_EXEC: ;
            ST_WB: begin
                bus.done      = 1'b1;
                bus.illegal   = dec.illegal;
                // Register 0 is hard-wired, so a write to it is suppressed.
                bus.rf_write  = !dec.illegal && (rd != '0);
                bus.rf_addr_w = rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= '0;
            op1_reg   <= '0;
            op2_reg   <= '0;
            oprn_reg  <= OP_NONE;
            zero_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && bus.instr_valid) begin
                instr_reg <= bus.instr[25:0];
            end
            if (state_reg == ST_EXEC) begin
                // Shifts take the value from rt and the amount from shamt.
                op1_reg  <= dec.is_shift ? bus.rf_data_r2 : bus.rf_data_r1;
                op2_reg  <= dec.is_shift ? {27'b0, shamt} : bus.rf_data_r2;
                oprn_reg <= dec.oprn;
            end
            if (state_reg == ST_WB) begin
                zero_reg <= bus.alu_zero;
            end
        end
    end

    assign bus.alu_op1   = op1_reg;
    assign bus.alu_op2   = op2_reg;
    assign bus.alu_oprn  = oprn_reg;
    assign bus.zero_flag = zero_reg;
    assign bus.rf_data_w = bus.alu_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a register-file and ALU model on the
// datapath side; expected values are hand-computed per vector.
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   wr_count;

    alu_sequencer_if bus();

    alu_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [32];
    logic [31:0] r1_q;
    logic [31:0] r2_q;

    function automatic logic [31:0] rf_init(input int idx);
        case (idx)
            1:       return 32'd5;
            2:       return 32'd7;
            4:       return 32'h0000_1234;
            5:       return 32'h0000_1234;
            6:       return 32'h0000_0001;
            9:       return 32'h00FF_00FF;
            11:      return 32'h0F0F_0F0F;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            if (bus.rf_read) begin
                r1_q <= rf[bus.rf_addr_r1];
                r2_q <= rf[bus.rf_addr_r2];
            end
            if (bus.rf_write) begin
                rf[bus.rf_addr_w] <= bus.rf_data_w;
                wr_count <= wr_count + 1;
            end
        end
    end

    assign bus.rf_data_r1 = r1_q;
    assign bus.rf_data_r2 = r2_q;

    always_comb begin
        case (bus.alu_oprn)
            4'h1:    bus.alu_out = bus.alu_op1 + bus.alu_op2;
            4'h2:    bus.alu_out = bus.alu_op1 - bus.alu_op2;
            4'h3:    bus.alu_out = bus.alu_op1 * bus.alu_op2;
            4'h4:    bus.alu_out = bus.alu_op1 >> bus.alu_op2[4:0];
            4'h5:    bus.alu_out = bus.alu_op1 << bus.alu_op2[4:0];
            4'h6:    bus.alu_out = bus.alu_op1 & bus.alu_op2;
            4'h7:    bus.alu_out = bus.alu_op1 | bus.alu_op2;
            4'h8:    bus.alu_out = ~(bus.alu_op1 | bus.alu_op2);
            4'h9:    bus.alu_out = {31'b0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
            default: bus.alu_out = 32'h0;
        endcase
        bus.alu_zero = (bus.alu_out == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b0, rs, rt, rd, sh, fn};
    endfunction

    // Full four-cycle transaction with checks in each phase.
    task automatic send(input logic [31:0] ins, input logic [31:0] e_op1,
                        input logic [31:0] e_op2, input logic [3:0] e_oprn,
                        input logic e_we, input logic [31:0] e_wdata,
                        input logic e_ill, input logic e_zero);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", {31'b0, bus.instr_ready}, 32'd1);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        check("read_strobe", {31'b0, bus.rf_read}, 32'd1);
        check("read_not_ready", {31'b0, bus.instr_ready}, 32'd0);
        check("read_addr_r1", {27'b0, bus.rf_addr_r1}, {27'b0, ins[25:21]});
        check("read_addr_r2", {27'b0, bus.rf_addr_r2}, {27'b0, ins[20:16]});
        @(negedge clk);
        check("exec_no_read", {31'b0, bus.rf_read}, 32'd0);
        check("exec_no_done", {31'b0, bus.done}, 32'd0);
        check("exec_not_ready", {31'b0, bus.instr_ready}, 32'd0);
        @(negedge clk);
        check("wb_done", {31'b0, bus.done}, 32'd1);
        check("wb_op1", bus.alu_op1, e_op1);
        check("wb_op2", bus.alu_op2, e_op2);
        check("wb_oprn", {28'b0, bus.alu_oprn}, {28'b0, e_oprn});
        check("wb_write", {31'b0, bus.rf_write}, {31'b0, e_we});
        check("wb_wdata", bus.rf_data_w, e_wdata);
        check("wb_illegal", {31'b0, bus.illegal}, {31'b0, e_ill});
        if (e_we) check("wb_waddr", {27'b0, bus.rf_addr_w}, {27'b0, ins[15:11]});
        @(negedge clk);
        check("post_done_low", {31'b0, bus.done}, 32'd0);
        check("post_write_low", {31'b0, bus.rf_write}, 32'd0);
        check("post_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("zero_flag", {31'b0, bus.zero_flag}, {31'b0, e_zero});
        $display("instr %h: op1 %h op2 %h oprn %0d wdata %h zero %0b", ins,
                 bus.alu_op1, bus.alu_op2, bus.alu_oprn, bus.rf_data_w, bus.zero_flag);
    endtask

    logic [31:0] hs [3];
    int          acc_cyc [3];
    int          k;
    int          ready_cycles;
    int          done_cycles;
    int          wr_before;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        wr_count        = 0;
        rst_n           = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("rst_rf_read", {31'b0, bus.rf_read}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_op1", bus.alu_op1, 32'd0);
        check("rst_oprn", {28'b0, bus.alu_oprn}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 4'h1, 1'b1, 32'd12, 1'b0, 1'b0);
        check("rf_r3", rf[3], 32'd12);
        send(rtype(5'd3, 5'd1, 5'd7, 5'd0, 6'h20), 32'd12, 32'd5, 4'h1, 1'b1, 32'd17, 1'b0, 1'b0);
        send(rtype(5'd4, 5'd5, 5'd8, 5'd0, 6'h22), 32'h1234, 32'h1234, 4'h2, 1'b1, 32'd0, 1'b0, 1'b1);

        // Reset dropped in EXEC must abort without a write.
        wr_before = wr_count;
        @(negedge clk);
        bus.instr       = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h22);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, bus.instr_ready}, 32'd1);
        check("arst_op1", bus.alu_op1, 32'd0);
        check("arst_op2", bus.alu_op2, 32'd0);
        check("arst_oprn", {28'b0, bus.alu_oprn}, 32'd0);
        check("arst_zero", {31'b0, bus.zero_flag}, 32'd0);
        check("arst_write", {31'b0, bus.rf_write}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_write", wr_count, wr_before);
        check("arst_ready_after", {31'b0, bus.instr_ready}, 32'd1);
        check("arst_no_done", {31'b0, bus.done}, 32'd0);

        send(rtype(5'd2, 5'd6, 5'd10, 5'd4, 6'h01), 32'd1, 32'd4, 4'h5, 1'b1, 32'h10, 1'b0, 1'b0);
        send(rtype(5'd0, 5'd9, 5'd17, 5'd8, 6'h02), 32'h00FF00FF, 32'd8, 4'h4, 1'b1, 32'h0000FF00, 1'b0, 1'b0);
        send(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h3f), 32'd5, 32'd7, 4'h0, 1'b0, 32'd0, 1'b1, 1'b1);
        wr_before = wr_count;
        send(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd5, 32'd7, 4'h1, 1'b0, 32'd12, 1'b0, 1'b0);
        check("rd0_no_write", wr_count, wr_before);
        send(rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h2c), 32'd5, 32'd7, 4'h3, 1'b1, 32'd35, 1'b0, 1'b0);
        send(rtype(5'd1, 5'd2, 5'd16, 5'd0, 6'h2a), 32'd5, 32'd7, 4'h9, 1'b1, 32'd1, 1'b0, 1'b0);

        // Continuous valid: accepts must land exactly four cycles apart.
        hs[0] = rtype(5'd9, 5'd11, 5'd12, 5'd0, 6'h25);
        hs[1] = rtype(5'd9, 5'd11, 5'd13, 5'd0, 6'h24);
        hs[2] = rtype(5'd9, 5'd11, 5'd14, 5'd0, 6'h27);
        k            = 0;
        ready_cycles = 0;
        done_cycles  = 0;
        @(negedge clk);
        bus.instr       = hs[0];
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) done_cycles++;
            if (bus.instr_ready) begin
                ready_cycles++;
                if (k < 3) acc_cyc[k] = c;
                k++;
            end
            @(negedge clk);
            if (k < 3) bus.instr = hs[k];
        end
        if (bus.done) done_cycles++;
        bus.instr_valid = 1'b0;
        check("hs_accepts", k, 32'd3);
        check("hs_ready_cycles", ready_cycles, 32'd3);
        check("hs_done_cycles", done_cycles, 32'd3);
        check("hs_acc0", acc_cyc[0], 32'd0);
        check("hs_acc1", acc_cyc[1], 32'd4);
        check("hs_acc2", acc_cyc[2], 32'd8);
        @(negedge clk);
        check("hs_or", rf[12], 32'h0FFF0FFF);
        check("hs_and", rf[13], 32'h000F000F);
        check("hs_nor", rf[14], 32'hF000F000);
        $display("handshake burst: accepts at cycles %0d %0d %0d", acc_cyc[0], acc_cyc[1], acc_cyc[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
